// File: rtl/weight_pkg.sv
// Shared types and default widths for the weight loader and the weight buffer it feeds.
package weight_pkg;
  localparam int B_ADDR_DEF = 9;
  localparam int B_DATA_DEF = 64;
  localparam int WB_DEPTH   = 2 ** B_ADDR_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/weight_loader.sv
// Sinks an AXI-Stream of weight words and writes them into the weight buffer,
// one word per accepted beat, checking framing against tlast.
//
// state | meaning
// IDLE  | waiting for start; stream not accepted
// LOAD  | accepting beats, one buffer write per handshake
// FIN   | load finished (normally or on framing error); done follows next cycle
module weight_loader
  import weight_pkg::*;
#(
  parameter int B_ADDR = B_ADDR_DEF,
  parameter int B_DATA = B_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [B_ADDR-1:0] base_addr,
  input  logic [B_ADDR:0]   len,
  input  logic [B_DATA-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              wr_en,
  output logic [B_ADDR-1:0] wr_addr,
  output logic [B_DATA-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [B_ADDR:0] CNT_ONE = (B_ADDR + 1)'(1);

  state_e            state_q, state_d;
  logic [B_ADDR-1:0] addr_q, addr_d;
  logic [B_ADDR:0]   cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [B_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [B_DATA-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;
  logic              last_cnt;

  assign hs       = (state_q == LOAD) && s_axis_tvalid;
  assign last_cnt = (cnt_q == CNT_ONE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = (state_q == FIN);
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          addr_d  = base_addr;
          cnt_d   = len;
          state_d = (len == '0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = s_axis_tdata;
          // address width gives the modulo-depth wrap for free
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (last_cnt || s_axis_tlast) begin
            state_d = FIN;
            // only a beat that is both the counted last and tagged last is clean
            err_d   = err_q | ~(last_cnt & s_axis_tlast);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_axis_tready = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: logs buffer writes and done pulses, then
// compares them against hand-computed sequences per scenario.
module tb_weight_loader;
  import weight_pkg::*;

  localparam int BA = B_ADDR_DEF;
  localparam int BD = B_DATA_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BA-1:0] base_addr = '0;
  logic [BA:0]   len = '0;
  logic [BD-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          wr_en;
  logic [BA-1:0] wr_addr;
  logic [BD-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  weight_loader #(.B_ADDR(BA), .B_DATA(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int start_cyc = 0;
  logic [BA-1:0] wr_addr_log[$];
  logic [BD-1:0] wr_data_log[$];
  int            wr_cyc_log[$];
  int            hs_cyc_log[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
      wr_cyc_log.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BD-1:0] word(input int t, input int i);
    return {16'hC0DE, 16'(t), 32'(i)};
  endfunction

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cyc_log.delete();
    hs_cyc_log.delete();
  endtask

  // entered and left at posedge+1
  task automatic do_start(input int b, input int l);
    base_addr = BA'(b);
    len       = (BA + 1)'(l);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // pat: 0 always valid, 1 toggles 1010..., 2 random stalls; last_at=0 means no tlast
  task automatic feed(input int t, input int n, input int last_at, input int pat,
                      output int acc, output logic busy0);
    int k;
    int d0;
    k = 0; d0 = done_cnt; acc = 0; busy0 = 1'b0;
    while (done_cnt == d0 && k < 200) begin
      if (acc < n) begin
        s_axis_tvalid = (pat == 0) ? 1'b1 : (pat == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
        s_axis_tdata  = word(t, acc);
        s_axis_tlast  = ((acc + 1) == last_at);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (s_axis_tvalid && s_axis_tready) begin
        hs_cyc_log.push_back(cyc);
        acc++;
      end
      @(posedge clk); #1;
      k++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (k >= 200) check("feed_timeout", 64'(k), 64'(0));
  endtask

  initial begin
    int acc;
    int d0;
    logic busy0;
    int exp_addr[4];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    check("rst_wr_en",  64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", wr_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err",  64'(err), 64'(0));
    @(posedge clk); #1;

    // 1: base 0, len 8, continuous stream
    clear_logs(); d0 = done_cnt;
    do_start(0, 8);
    feed(1, 8, 8, 0, acc, busy0);
    check("t1_busy", 64'(busy0), 64'(1));
    check("t1_nwr", 64'(wr_addr_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      check("t1_addr", 64'(wr_addr_log[i]), 64'(i));
      check("t1_data", wr_data_log[i], word(1, i));
      check("t1_cyc", 64'(wr_cyc_log[i]), 64'(wr_cyc_log[0] + i));
    end
    if (wr_cyc_log.size() == 8) check("t1_done_cyc", 64'(done_cyc), 64'(wr_cyc_log[7] + 1));
    check("t1_ndone", 64'(done_cnt - d0), 64'(1));
    check("t1_err", 64'(err), 64'(0));
    check("t1_busy_end", 64'(busy), 64'(0));

    // 2: address wrap
    exp_addr = '{510, 511, 0, 1};
    clear_logs();
    do_start(510, 4);
    feed(2, 4, 4, 0, acc, busy0);
    check("t2_nwr", 64'(wr_addr_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      check("t2_addr", 64'(wr_addr_log[i]), 64'(exp_addr[i]));
      check("t2_data", wr_data_log[i], word(2, i));
    end
    check("t2_err", 64'(err), 64'(0));

    // 3: stalls, toggled then random
    for (int p = 1; p <= 2; p++) begin
      clear_logs();
      do_start(100, 4);
      feed(2 + p, 4, 4, p, acc, busy0);
      check("t3_nwr", 64'(wr_addr_log.size()), 64'(4));
      check("t3_nhs", 64'(hs_cyc_log.size()), 64'(4));
      for (int i = 0; i < 4 && i < wr_addr_log.size() && i < hs_cyc_log.size(); i++) begin
        check("t3_addr", 64'(wr_addr_log[i]), 64'(100 + i));
        check("t3_data", wr_data_log[i], word(2 + p, i));
        check("t3_lat", 64'(wr_cyc_log[i]), 64'(hs_cyc_log[i] + 1));
      end
      check("t3_err", 64'(err), 64'(0));
    end

    // 4: early tlast, then err cleared by next start
    clear_logs(); d0 = done_cnt;
    do_start(20, 6);
    feed(5, 6, 3, 0, acc, busy0);
    check("t4_nwr", 64'(wr_addr_log.size()), 64'(3));
    check("t4_err", 64'(err), 64'(1));
    check("t4_ndone", 64'(done_cnt - d0), 64'(1));
    clear_logs();
    do_start(40, 2);
    @(negedge clk);
    check("t4_err_clr", 64'(err), 64'(0));
    @(posedge clk); #1;
    feed(6, 2, 2, 0, acc, busy0);
    check("t4b_nwr", 64'(wr_addr_log.size()), 64'(2));
    check("t4b_err", 64'(err), 64'(0));

    // 5: missing tlast, surplus beat left on the stream
    clear_logs();
    do_start(60, 3);
    feed(7, 4, 0, 0, acc, busy0);
    check("t5_acc", 64'(acc), 64'(3));
    check("t5_nwr", 64'(wr_addr_log.size()), 64'(3));
    check("t5_err", 64'(err), 64'(1));
    check("t5_tready", 64'(s_axis_tready), 64'(0));

    // 6: reset after two beats, then a zero-length load
    clear_logs(); d0 = done_cnt;
    do_start(0, 8);
    s_axis_tvalid = 1'b1; s_axis_tdata = word(8, 0);
    @(posedge clk); #1;
    s_axis_tdata = word(8, 1);
    @(posedge clk); #1;
    rst = 1'b1; s_axis_tdata = word(8, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_wr_en", 64'(wr_en), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_tready", 64'(s_axis_tready), 64'(0));
    rst = 1'b0; s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_nwr", 64'(wr_addr_log.size()), 64'(2));
    check("t6_nodone", 64'(done_cnt - d0), 64'(0));
    clear_logs(); d0 = done_cnt;
    do_start(5, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_len0_ndone", 64'(done_cnt - d0), 64'(1));
    check("t6_len0_dcyc", 64'(done_cyc), 64'(start_cyc + 2));
    check("t6_len0_nwr", 64'(wr_addr_log.size()), 64'(0));
    check("t6_len0_err", 64'(err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
